// File: rtl/sipo_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sipo_frame_ctrl_if                                          |
// | Brief  : Serial-in / parallel-out port bundle for sipo_frame_ctrl.   |
// |          parity_err exists only when SIPO_PARITY_EN is defined.      |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             parity_err;

  modport master (
    output sin, sin_en, out_ready,
    input  out_data, out_valid, busy, frame_err, overrun, parity_err
  );

  modport slave (
    input  sin, sin_en, out_ready,
    output out_data, out_valid, busy, frame_err, overrun, parity_err
  );
`else
  modport master (
    output sin, sin_en, out_ready,
    input  out_data, out_valid, busy, frame_err, overrun
  );

  modport slave (
    input  sin, sin_en, out_ready,
    output out_data, out_valid, busy, frame_err, overrun
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sipo_frame_ctrl                                             |
// | Brief  : Framed serial receiver: start bit, WIDTH data bits (LSB     |
// |          first), optional even parity (SIPO_PARITY_EN), stop bit,    |
// |          one-deep valid/ready holding register.                      |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input wire              clk,
  input wire              rst,
  sipo_frame_ctrl_if.slave bus
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sipo_q, sipo_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic             accept;
`ifdef SIPO_PARITY_EN
  logic             perr_q, perr_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sipo_d      = sipo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    word_done   = 1'b0;
    accept      = out_valid_q && bus.out_ready;
`ifdef SIPO_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif

    if (bus.sin_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.sin) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
`ifdef SIPO_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          sipo_d = {bus.sin, sipo_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
`ifdef SIPO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        ST_PARITY: begin
          // Even parity: data bits plus parity bit must have an even count of ones.
          perr_d  = bus.sin ^ (^sipo_q);
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!bus.sin) begin
            frame_err_d = 1'b1;
`ifdef SIPO_PARITY_EN
          end else if (perr_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            word_done = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A simultaneous accept frees the holding register for the new word.
    if (word_done) begin
      if (!out_valid_q || accept) begin
        out_data_d  = sipo_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sipo_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sipo_q       <= sipo_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_sipo_frame_ctrl                                          |
// | Brief  : Directed + randomized frame bench with a frame-level model. |
// |          Parity scenarios are active when SIPO_PARITY_EN is defined. |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model of the holding register.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic en, input logic rdy);
    @(negedge clk);
    bus.sin       = b;
    bus.sin_en    = en;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    m_valid = 1'b0;
    check1("consume_valid", bus.out_valid, 1'b0);
  endtask

  // One frame: gap idle cycles before every strobe, out_ready only on the stop edge.
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input logic pflip,
                            input int gap, input logic rdy, input logic tail);
    logic q[$];
    logic acc, good, exp_ovr;
    q.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) q.push_back(d[i]);
`ifdef SIPO_PARITY_EN
    q.push_back((^d) ^ pflip);
`endif
    q.push_back(stop);
    for (int k = 0; k < q.size(); k++) begin
      for (int g = 0; g < gap; g++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (k == q.size() - 1) begin
        check1("valid_before_stop", bus.out_valid, m_valid);
        cyc(q[k], 1'b1, rdy);
      end else begin
        cyc(q[k], 1'b1, 1'b0);
        if (k == 0) check1("busy_after_start", bus.busy, 1'b1);
      end
    end
    acc = m_valid && rdy;
`ifdef SIPO_PARITY_EN
    good = stop && !pflip;
`else
    good = stop;
`endif
    exp_ovr = 1'b0;
    if (good) begin
      if (!m_valid || acc) begin
        m_valid = 1'b1;
        m_data  = d;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
    check1("busy_after_stop", bus.busy, 1'b0);
    check1("frame_err", bus.frame_err, !stop);
    check1("overrun", bus.overrun, exp_ovr);
`ifdef SIPO_PARITY_EN
    check1("parity_err", bus.parity_err, stop && pflip);
`endif
    check1("out_valid", bus.out_valid, m_valid);
    if (m_valid) check8("out_data", bus.out_data, m_data);
    if (tail) begin
      cyc(1'b1, 1'b0, 1'b0);
      check1("frame_err_drop", bus.frame_err, 1'b0);
      check1("overrun_drop", bus.overrun, 1'b0);
`ifdef SIPO_PARITY_EN
      check1("parity_err_drop", bus.parity_err, 1'b0);
`endif
      check1("out_valid_hold", bus.out_valid, m_valid);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.sin       = 1'b1;
    bus.sin_en    = 1'b0;
    bus.out_ready = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_frame_err", bus.frame_err, 1'b0);
    check1("rst_overrun", bus.overrun, 1'b0);
    check8("rst_out_data", bus.out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Idle strobes with sin high must not start a frame.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    check1("idle_busy", bus.busy, 1'b0);

    // Single frame 0x4A, then held stable.
    send_frame(8'h4A, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check8("hold_data", bus.out_data, 8'h4A);
      check1("hold_valid", bus.out_valid, 1'b1);
    end
    consume();

    // Gapped strobes, every third cycle.
    send_frame(8'h4A, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    consume();

    // Framing error then recovery.
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    consume();

    // Overrun, then simultaneous accept + load.
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    send_frame(8'h33, 1'b1, 1'b0, 0, 1'b1, 1'b1);

    // Asynchronous reset after four data bits, with a word still held.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("async_rst_busy", bus.busy, 1'b0);
    check1("async_rst_valid", bus.out_valid, 1'b0);
    check8("async_rst_data", bus.out_data, 8'h00);
    m_valid = 1'b0;
    m_data  = '0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    consume();

`ifdef SIPO_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    consume();
    send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b1);
`endif

    // Randomized frames, including back-to-back starts right after stop.
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
